hms_clock_display: RTL and testbench
====================================

# hms_clock_display

Parametrised HH:MM:SS / MM:SS real-time clock with a multiplexed 7-segment driver, running entirely on the board clock. Fractional-rate derived clocks are replaced by single-cycle clock enables. It adds 12/24-hour modes, run/hold control, and manual minute/hour setting. It sits directly on the board's 8-digit anode/cathode pins (AN, C) and is the time source for the display top level.

## Interface
Parameters:
- TICK_DIV, 100_000_000, clock cycles per second tick (≥2)
- SCAN_DIV, 62_500, clock cycles each digit is driven per scan slot (≥1)
- NUM_DIGITS, 6, digits displayed: 4 (MM:SS) or 6 (HH:MM:SS); any other value is a compile-time error
- H24, 1, 1 = 00–23 hours; 0 = 1–12 hours

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  board clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- run  in  1  1 = time advances on each second tick; 0 = time and prescaler hold
- set_min  in  1  single-cycle pulse (pre-debounced), minutes +1
- set_hr  in  1  single-cycle pulse (pre-debounced), hours +1; ignored when NUM_DIGITS=4
- AN  out  8  active-low anode one-hot; digits ≥ NUM_DIGITS always 1
- C  out  7  active-low segments {g,f,e,d,c,b,a}
- tick_1hz  out  1  one-cycle pulse on each applied second tick
- time_bcd  out  24  {hr_t,hr_o,min_t,min_o,sec_t,sec_o}, 4-bit BCD each

## Operation
- Prescaler: counts 0..TICK_DIV-1 while run=1. tick fires in the cycle the count equals TICK_DIV-1, then wraps to 0. It holds its value while run=0.
- Time is stored as BCD digits. No division is used.
  - sec_o: mod 10. sec_t: mod 6.
  - min_o: mod 10. min_t: mod 6.
  - hours: single BCD pair with explicit rollover.
- Carries ripple in the same cycle as the tick:
  - 59 s → 00 s with minutes +1.
  - 59 min → 00 min with hours +1 when NUM_DIGITS=6.
  - With NUM_DIGITS=4, hours stay 00 and minutes wrap 59 → 00.
- Hour rollover:
  - H24=1: 23 → 00.
  - H24=0: 12 → 01, and 11 → 12 (no AM/PM).
- set_min: minutes +1 mod 60 with no carry into hours; seconds clear to 00. If a tick occurs in the same cycle, that tick is discarded.
- set_hr: hours +1 with rollover as above. Seconds and minutes are unaffected, and a coincident tick is applied normally.
- set_min and set_hr in the same cycle: both are applied.
- set_* work regardless of run.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1. At wrap, digit index advances 0..NUM_DIGITS-1 → 0.
  - Digit 0 = sec_o (rightmost), 1 = sec_t, 2 = min_o, 3 = min_t, 4 = hr_o, 5 = hr_t.
  - Scanning runs independent of run.
- Segment codes: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0011000, else 1111111.

## Timing
- Reset values:
  - time = 00:00:00 (H24=0: 12:00:00), time_bcd accordingly.
  - Prescaler, scan counter and digit index = 0.
  - AN = 8'hFF, C = 7'h7F, tick_1hz = 0.
- AN/C are registered. The first valid drive (digit 0) appears on the first clock edge after reset deasserts.
- When the digit index changes, AN and C change on the same edge and stay together; there is never a cycle with AN for one digit and C for another.
- time_bcd updates on the edge after tick or set_*. tick_1hz is asserted in that same cycle, except when the tick is discarded.
- A display change is visible the next time the affected digit is scanned.
- Reset mid-count or mid-scan takes effect immediately and asynchronously, producing the reset values above.

## Structure
- Package hms_clock_pkg holds:
  - SEG_* digit constants and SEG_BLANK.
  - seg7 function: 4-bit BCD → 7-bit active-low.
  - AN_OFF = 8'hFF.
- Sub-module bcd_digit_counter with parameter MOD and ports inc, clr, value[3:0], carry. It is instantiated for sec_o, sec_t, min_o and min_t.
- Hour logic, prescaler and scan mux stay in the top level.
- Target size is about 200 lines of RTL.

## Test plan
- Reset: assert reset mid-scan with time 12:34:56 → AN=FF, C=7F, time_bcd=000000 immediately. First edge after release gives AN=FE, C=1000000.
- Counting, TICK_DIV=4, run=1: 240 cycles after reset → time_bcd=000100, with exactly 60 tick_1hz pulses at 4-cycle spacing.
- Rollover with H24=1, preload via set_* to 23:59:59:
  - One tick → 000000.
  - With H24=0, 12:59:59 → 010000 and 11:59:59 → 120000.
- Scan, NUM_DIGITS=4, SCAN_DIV=2: AN sequence FE, FD, FB, F7, FE, each held 2 cycles. C matches each digit's code. AN[7:4] stay 1.
- Set/tick collision at 00:00:59:
  - set_min coincident with tick → 00:01:00, tick_1hz=0.
  - At minutes=59, set_min → minutes 00 and hours unchanged.
- Hold: run=0 for 100 cycles → time_bcd and prescaler unchanged, while set_hr still increments hours and the scan continues.

Source files
------------

// File: rtl/hms_clock_pkg.sv
// ---------------------------------------------------------------------------
// hms_clock_pkg
// Shared constants and helpers for the HH:MM:SS clock display.
//   SEG_0..SEG_9, SEG_BLANK : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   AN_OFF                  : all eight anodes released (active-low)
//   time_bcd_t              : packed layout of the time_bcd output
//   seg7()                  : 4-bit BCD digit -> active-low segment code
// ---------------------------------------------------------------------------
package hms_clock_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [7:0] AN_OFF = 8'hFF;

  typedef struct packed {
    logic [3:0] hr_t;
    logic [3:0] hr_o;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } time_bcd_t;

  // Codes 10..15 are not decimal digits and show as a dark digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hms_clock_display_if.sv
// ---------------------------------------------------------------------------
// hms_clock_display_if
// Control and display signals of the clock display, bundled.
//   run, set_min, set_hr : controls into the clock (set_* are 1-cycle pulses)
//   AN, C                : active-low anode one-hot and segment pins
//   tick_1hz, time_bcd   : applied-second pulse and current time in BCD
// master = the side driving the controls; slave = the clock itself.
// ---------------------------------------------------------------------------
interface hms_clock_display_if;
  import hms_clock_pkg::*;

  logic        run;
  logic        set_min;
  logic        set_hr;
  logic [7:0]  AN;
  logic [6:0]  C;
  logic        tick_1hz;
  time_bcd_t   time_bcd;

  modport master (
    output run, set_min, set_hr,
    input  AN, C, tick_1hz, time_bcd
  );

  modport slave (
    input  run, set_min, set_hr,
    output AN, C, tick_1hz, time_bcd
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter
// One BCD digit counting 0..MOD-1.
//   clock, reset : rising-edge clock, asynchronous active-high reset (-> 0)
//   inc          : advance by one this cycle
//   clr          : force to 0 (wins over inc)
//   value        : current digit
//   carry        : combinational, high when inc wraps the digit back to 0
// ---------------------------------------------------------------------------
module bcd_digit_counter
  import hms_clock_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] value,
  output logic       carry
);

  localparam logic [3:0] LAST = 4'(MOD - 1);

  logic [3:0] value_q, value_d;

  assign carry = inc && (value_q == LAST);
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = 4'd0;
    end else if (inc) begin
      value_d = (value_q == LAST) ? 4'd0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) value_q <= 4'd0;
    else       value_q <= value_d;
  end

endmodule

// File: rtl/hms_clock_display.sv
// ---------------------------------------------------------------------------
// hms_clock_display
// HH:MM:SS (or MM:SS) real-time clock driving a multiplexed 8-digit
// 7-segment display. Everything runs on the board clock; the 1 Hz rate and
// the digit scan rate are single-cycle enables, not derived clocks.
//   clock : board clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : slave side of hms_clock_display_if
//           run      - 1 = prescaler and time advance, 0 = both hold
//           set_min  - pulse: minutes +1 (no carry), seconds -> 00, eats a same-cycle tick
//           set_hr   - pulse: hours +1 (ignored with 4 digits)
//           AN, C    - registered active-low anodes / segments
//           tick_1hz - one cycle high for each applied second tick
//           time_bcd - {hr_t,hr_o,min_t,min_o,sec_t,sec_o}
// ---------------------------------------------------------------------------
module hms_clock_display
  import hms_clock_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int SCAN_DIV   = 62_500,
  parameter int NUM_DIGITS = 6,
  parameter int H24        = 1
) (
  input  logic               clock,
  input  logic               reset,
  hms_clock_display_if.slave bus
);

  if (!(NUM_DIGITS == 4 || NUM_DIGITS == 6)) begin : g_bad_num_digits
    $error("hms_clock_display: NUM_DIGITS must be 4 or 6");
  end

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // A 12-hour clock has no hour 00, so it powers up at 12.
  localparam logic [7:0] HR_RESET = (NUM_DIGITS == 6 && H24 == 0) ? 8'h12 : 8'h00;

  // ---------------- second prescaler ----------------
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          tick_apply;

  assign tick       = bus.run && (presc_q == PW'(TICK_DIV - 1));
  // set_min restarts the seconds, so a coincident tick is dropped.
  assign tick_apply = tick && !bus.set_min;

  always_comb begin
    presc_d = presc_q;
    if (bus.run) presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // ---------------- seconds / minutes ----------------
  logic [3:0] sec_o_val, sec_t_val, min_o_val, min_t_val;
  logic       sec_o_carry, sec_t_carry, min_o_carry, min_t_carry;
  logic       hour_carry;

  bcd_digit_counter #(.MOD(10)) u_sec_o (
    .clock(clock), .reset(reset), .inc(tick_apply), .clr(bus.set_min),
    .value(sec_o_val), .carry(sec_o_carry)
  );

  bcd_digit_counter #(.MOD(6)) u_sec_t (
    .clock(clock), .reset(reset), .inc(sec_o_carry), .clr(bus.set_min),
    .value(sec_t_val), .carry(sec_t_carry)
  );

  bcd_digit_counter #(.MOD(10)) u_min_o (
    .clock(clock), .reset(reset), .inc(sec_t_carry || bus.set_min), .clr(1'b0),
    .value(min_o_val), .carry(min_o_carry)
  );

  bcd_digit_counter #(.MOD(6)) u_min_t (
    .clock(clock), .reset(reset), .inc(min_o_carry), .clr(1'b0),
    .value(min_t_val), .carry(min_t_carry)
  );

  // A minute wrap caused by set_min must not reach the hours.
  assign hour_carry = min_t_carry && !bus.set_min;

  // ---------------- hours ----------------
  logic [7:0] hr_q, hr_d;

  function automatic logic [7:0] bcd_pair_inc(input logic [7:0] h);
    if (h[3:0] == 4'd9) return {h[7:4] + 4'd1, 4'd0};
    return {h[7:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] hr_step(input logic [7:0] h);
    if (H24 != 0) return (h == 8'h23) ? 8'h00 : bcd_pair_inc(h);
    return (h == 8'h12) ? 8'h01 : bcd_pair_inc(h);
  endfunction

  // set_hr and a carry in the same cycle are two separate hour steps.
  always_comb begin
    hr_d = hr_q;
    if (NUM_DIGITS == 6) begin
      if (bus.set_hr) hr_d = hr_step(hr_d);
      if (hour_carry) hr_d = hr_step(hr_d);
    end
  end

  // ---------------- display scan ----------------
  logic [SW-1:0] scan_q, scan_d;
  logic [2:0]    dig_q, dig_d;
  logic          scan_wrap;
  logic [3:0]    cur_digit;
  logic [7:0]    an_q, an_d;
  logic [6:0]    c_q, c_d;
  logic          tick_q;

  assign scan_wrap = (scan_q == SW'(SCAN_DIV - 1));

  always_comb begin
    scan_d = scan_wrap ? '0 : scan_q + SW'(1);
    dig_d  = dig_q;
    if (scan_wrap) dig_d = (dig_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : dig_q + 3'd1;
  end

  always_comb begin
    cur_digit = 4'hF;
    case (dig_q)
      3'd0:    cur_digit = sec_o_val;
      3'd1:    cur_digit = sec_t_val;
      3'd2:    cur_digit = min_o_val;
      3'd3:    cur_digit = min_t_val;
      3'd4:    cur_digit = hr_q[3:0];
      3'd5:    cur_digit = hr_q[7:4];
      default: cur_digit = 4'hF;
    endcase
  end

  // Anode and segments come from the same dig_q sample and are registered
  // together, so they can never disagree about which digit is lit.
  always_comb begin
    an_d = AN_OFF & ~(8'd1 << dig_q);
    c_d  = seg7(cur_digit);
  end

  // ---------------- state ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      hr_q    <= HR_RESET;
      scan_q  <= '0;
      dig_q   <= 3'd0;
      an_q    <= AN_OFF;
      c_q     <= SEG_BLANK;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hr_q    <= hr_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      c_q     <= c_d;
      tick_q  <= tick_apply;
    end
  end

  assign bus.AN       = an_q;
  assign bus.C        = c_q;
  assign bus.tick_1hz = tick_q;
  assign bus.time_bcd = {hr_q, min_t_val, min_o_val, sec_t_val, sec_o_val};

endmodule

// File: tb/tb_hms_clock_display.sv
// ---------------------------------------------------------------------------
// tb_hms_clock_display
// Three clock instances share one stimulus stream:
//   dut0: 6 digits, 24 h, SCAN_DIV=1
//   dut1: 6 digits, 12 h, SCAN_DIV=3
//   dut2: 4 digits (MM:SS), SCAN_DIV=2
// All use TICK_DIV=4. A reference model keeps h/m/s as plain integers;
// each cycle it pushes the expected outputs into a queue, and a monitor
// pops and compares them shortly after the clock edge.
// ---------------------------------------------------------------------------
module tb_hms_clock_display;

  localparam int N  = 3;
  localparam int TD = 4;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic set_min = 1'b0;
  logic set_hr = 1'b0;

  always #5 clk = ~clk;

  logic [7:0]  an_w [N];
  logic [6:0]  c_w  [N];
  logic        tk_w [N];
  logic [23:0] t_w  [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      hms_clock_display_if ifc ();
      assign ifc.run     = run;
      assign ifc.set_min = set_min;
      assign ifc.set_hr  = set_hr;

      hms_clock_display #(
        .TICK_DIV  (TD),
        .SCAN_DIV  ((gi == 0) ? 1 : ((gi == 1) ? 3 : 2)),
        .NUM_DIGITS((gi == 2) ? 4 : 6),
        .H24       ((gi == 1) ? 0 : 1)
      ) u_dut (
        .clock(clk),
        .reset(rst),
        .bus  (ifc)
      );

      assign an_w[gi] = ifc.AN;
      assign c_w[gi]  = ifc.C;
      assign tk_w[gi] = ifc.tick_1hz;
      assign t_w[gi]  = ifc.time_bcd;
    end
  endgenerate

  function automatic int cfg_nd(int k);  return (k == 2) ? 4 : 6; endfunction
  function automatic int cfg_h24(int k); return (k == 1) ? 0 : 1; endfunction
  function automatic int cfg_sd(int k);  return (k == 0) ? 1 : ((k == 1) ? 3 : 2); endfunction

  // ---------------- reference model ----------------
  int mh [N], mm [N], ms [N], mpres [N], mscn [N], mdix [N];

  typedef struct {
    int          dut;
    logic [23:0] t;
    logic        tk;
    logic [7:0]  an;
    logic [6:0]  c;
  } exp_t;

  exp_t sbq [$];

  int checks = 0;
  int errors = 0;
  int tick_cnt0 = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: actual %0h required %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] mbcd(int k);
    return {4'(mh[k] / 10), 4'(mh[k] % 10), 4'(mm[k] / 10), 4'(mm[k] % 10),
            4'(ms[k] / 10), 4'(ms[k] % 10)};
  endfunction

  function automatic int mdigit(int k, int d);
    case (d)
      0: return ms[k] % 10;
      1: return ms[k] / 10;
      2: return mm[k] % 10;
      3: return mm[k] / 10;
      4: return mh[k] % 10;
      default: return mh[k] / 10;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mh[k]    = (cfg_nd(k) == 6 && cfg_h24(k) == 0) ? 12 : 0;
      mm[k]    = 0;
      ms[k]    = 0;
      mpres[k] = 0;
      mscn[k]  = 0;
      mdix[k]  = 0;
    end
  endtask

  task automatic hour_up(input int k);
    if (cfg_nd(k) == 6) begin
      if (cfg_h24(k) != 0) mh[k] = (mh[k] + 1) % 24;
      else                 mh[k] = (mh[k] == 12) ? 1 : mh[k] + 1;
    end
  endtask

  // Expected outputs after the next rising edge, given the current inputs.
  task automatic model_cycle(input int k);
    exp_t e;
    logic tick;
    e.dut = k;
    e.an  = 8'hFF & ~(8'd1 << mdix[k]);
    e.c   = SEG_TAB[mdigit(k, mdix[k])];
    if (mscn[k] == cfg_sd(k) - 1) begin
      mscn[k] = 0;
      mdix[k] = (mdix[k] + 1) % cfg_nd(k);
    end else begin
      mscn[k]++;
    end
    tick = run && (mpres[k] == TD - 1);
    if (run) mpres[k] = (mpres[k] + 1) % TD;
    if (set_hr) hour_up(k);
    if (set_min) begin
      mm[k] = (mm[k] + 1) % 60;
      ms[k] = 0;
    end else if (tick) begin
      ms[k]++;
      if (ms[k] == 60) begin
        ms[k] = 0;
        mm[k]++;
        if (mm[k] == 60) begin
          mm[k] = 0;
          hour_up(k);
        end
      end
    end
    e.tk = tick && !set_min;
    e.t  = mbcd(k);
    sbq.push_back(e);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic r, input logic sm, input logic sh);
    @(negedge clk);
    run = r;
    set_min = sm;
    set_hr = sh;
    for (int k = 0; k < N; k++) model_cycle(k);
    @(posedge clk);
  endtask

  task automatic run_n(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pulse_hr(input int n);
    repeat (n) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < N; k++) begin
      chk({tag, "_an"}, k, 32'(an_w[k]), 32'h0000_00FF);
      chk({tag, "_c"}, k, 32'(c_w[k]), 32'h0000_007F);
      chk({tag, "_time"}, k, 32'(t_w[k]), 32'(mbcd(k)));
      chk({tag, "_tick"}, k, 32'(tk_w[k]), 32'd0);
    end
  endtask

  task automatic check_first_scan(input string tag);
    for (int k = 0; k < N; k++) begin
      chk({tag, "_an"}, k, 32'(an_w[k]), 32'h0000_00FE);
      chk({tag, "_c"}, k, 32'(c_w[k]), 32'b1000000);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  exp_t me;
  always @(posedge clk) begin
    #2;
    while (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("time_bcd", me.dut, 32'(t_w[me.dut]), 32'(me.t));
      chk("tick_1hz", me.dut, 32'(tk_w[me.dut]), 32'(me.tk));
      chk("AN", me.dut, 32'(an_w[me.dut]), 32'(me.an));
      chk("C", me.dut, 32'(c_w[me.dut]), 32'(me.c));
      if (me.dut == 0 && tk_w[0] === 1'b1) tick_cnt0++;
      if (me.dut == 0 && me.tk)
        $display("[%0t] dut0 tick time_bcd=%06h AN=%02h C=%07b", $time, t_w[0], an_w[0], c_w[0]);
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2 check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // counting from reset: 240 cycles -> one minute
    tick_cnt0 = 0;
    step(1'b1, 1'b0, 1'b0);
    #3 check_first_scan("first_scan");
    run_n(239);
    #3;
    chk("count_tick_pulses", 0, 32'(tick_cnt0), 32'd60);
    chk("count_1min", 0, 32'(t_w[0]), 32'h0000_0100);
    chk("count_1min", 1, 32'(t_w[1]), 32'h0012_0100);
    chk("count_1min", 2, 32'(t_w[2]), 32'h0000_0100);

    // preload 23:59:00 (dut1 11:59:00), then run into the rollover
    pulse_min(58);
    pulse_hr(23);
    run_n(240);
    #3;
    chk("roll_23_to_00", 0, 32'(t_w[0]), 32'h0000_0000);
    chk("roll_11_to_12", 1, 32'(t_w[1]), 32'h0012_0000);
    chk("roll_mmss", 2, 32'(t_w[2]), 32'h0000_0000);

    pulse_min(59);
    run_n(240);
    #3;
    chk("roll_00_to_01", 0, 32'(t_w[0]), 32'h0001_0000);
    chk("roll_12_to_01", 1, 32'(t_w[1]), 32'h0001_0000);
    chk("roll_mmss_4dig", 2, 32'(t_w[2]), 32'h0000_0000);

    // set_min coincident with a tick at :59
    run_n(239);
    step(1'b1, 1'b1, 1'b0);
    #3;
    chk("collide_time", 0, 32'(t_w[0]), 32'h0001_0100);
    chk("collide_tick", 0, 32'(tk_w[0]), 32'd0);
    chk("collide_time", 2, 32'(t_w[2]), 32'h0000_0100);
    step(1'b0, 1'b0, 1'b0);

    // minute wrap from set_min does not carry into hours
    pulse_min(58);
    pulse_min(1);
    #3;
    chk("setmin_wrap", 0, 32'(t_w[0]), 32'h0001_0000);
    chk("setmin_wrap", 1, 32'(t_w[1]), 32'h0001_0000);

    // hold with the prescaler part-way, set_hr still works
    run_n(2);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, i == 50);
    #3 chk("hold_time", 0, 32'(t_w[0]), 32'h0002_0000);
    run_n(2);
    #3;
    chk("resume_time", 0, 32'(t_w[0]), 32'h0002_0001);
    chk("resume_tick", 0, 32'(tk_w[0]), 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
    end

    // asynchronous reset between clock edges
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    #3 check_first_scan("rst_first_scan");
    run_n(60);
    #3;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
